// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: FSM state encoding, default message length and
// the plaintext character filter used by the PRGA decrypt stage.
package rc4_pkg;

   localparam int MSG_LEN_DEFAULT = 32;

   localparam logic [7:0] CHAR_LO    = 8'h61;
   localparam logic [7:0] CHAR_HI    = 8'h7A;
   localparam logic [7:0] CHAR_SPACE = 8'h20;

   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      READ_I    = 4'd1,
      WAIT_I    = 4'd2,
      READ_J    = 4'd3,
      WAIT_J    = 4'd4,
      WRITE_I   = 4'd5,
      WRITE_J   = 4'd6,
      READ_F    = 4'd7,
      WAIT_F    = 4'd8,
      WRITE_OUT = 4'd9,
      DONE      = 4'd10
   } state_t;

   function automatic logic is_legal_char(input logic [7:0] c);
      return ((c >= CHAR_LO) && (c <= CHAR_HI)) || (c == CHAR_SPACE);
   endfunction

endpackage

// File: rtl/prga_decrypt.sv
// RC4 PRGA decryption stage: walks the S array, XORs the keystream with the
// ciphertext ROM and writes plaintext, aborting on the first illegal character.
module prga_decrypt
   import rc4_pkg::*;
#(
   parameter  int MSG_LEN = MSG_LEN_DEFAULT,
   localparam int AW      = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   output logic          finish,
   output logic          valid,
   output logic [7:0]    s_address,
   output logic [7:0]    s_data,
   output logic          s_wren,
   input  logic [7:0]    s_q,
   output logic [AW-1:0] rom_address,
   input  logic [7:0]    rom_q,
   output logic [AW-1:0] ram_address,
   output logic [7:0]    ram_data,
   output logic          ram_wren
);

   localparam logic [7:0] LAST_K = 8'(MSG_LEN - 1);

   state_t r_state;
   state_t w_next_state;

   logic [7:0]    r_i, r_j, r_k, r_si, r_sj;
   logic [7:0]    w_i, w_j, w_k, w_si, w_sj;
   logic          r_finish, r_valid, r_s_wren, r_ram_wren;
   logic          w_finish, w_valid, w_s_wren, w_ram_wren;
   logic [7:0]    r_s_address, r_s_data, r_ram_data;
   logic [7:0]    w_s_address, w_s_data, w_ram_data;
   logic [AW-1:0] r_rom_address, r_ram_address;
   logic [AW-1:0] w_rom_address, w_ram_address;

   // State register
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_next_state = READ_I;
            end else begin
               w_next_state = IDLE;
            end
         end
         READ_I:  w_next_state = WAIT_I;
         WAIT_I:  w_next_state = READ_J;
         READ_J:  w_next_state = WAIT_J;
         WAIT_J:  w_next_state = WRITE_I;
         WRITE_I: w_next_state = WRITE_J;
         WRITE_J: w_next_state = READ_F;
         READ_F:  w_next_state = WAIT_F;
         WAIT_F:  w_next_state = WRITE_OUT;
         WRITE_OUT: begin
            // r_ram_data holds the byte being written this cycle
            if (!is_legal_char(r_ram_data) || (r_k == LAST_K)) begin
               w_next_state = DONE;
            end else begin
               w_next_state = READ_I;
            end
         end
         DONE:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // Output and datapath next values; registered so each state sees its own values
   always_comb begin
      w_i           = r_i;
      w_j           = r_j;
      w_k           = r_k;
      w_si          = r_si;
      w_sj          = r_sj;
      w_valid       = r_valid;
      w_s_address   = r_s_address;
      w_s_data      = r_s_data;
      w_rom_address = r_rom_address;
      w_ram_address = r_ram_address;
      w_ram_data    = r_ram_data;
      w_finish      = 1'b0;
      w_s_wren      = 1'b0;
      w_ram_wren    = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_k         = 8'd0;
               w_i         = 8'd1;
               w_j         = 8'd0;
               w_valid     = 1'b0;
               w_s_address = 8'd1;
            end else begin
               w_s_address = r_s_address;
            end
         end
         WAIT_I: begin
            w_si        = s_q;
            w_j         = r_j + s_q;
            w_s_address = r_j + s_q;
         end
         WAIT_J: begin
            w_sj        = s_q;
            w_s_address = r_i;
            w_s_data    = s_q;
            w_s_wren    = 1'b1;
         end
         WRITE_I: begin
            w_s_address = r_j;
            w_s_data    = r_si;
            w_s_wren    = 1'b1;
         end
         WRITE_J: begin
            w_s_address   = r_si + r_sj;
            w_rom_address = r_k[AW-1:0];
         end
         WAIT_F: begin
            w_ram_address = r_k[AW-1:0];
            w_ram_data    = s_q ^ rom_q;
            w_ram_wren    = 1'b1;
         end
         WRITE_OUT: begin
            if (w_next_state == DONE) begin
               w_finish = 1'b1;
               w_valid  = is_legal_char(r_ram_data);
            end else begin
               w_k         = r_k + 8'd1;
               w_i         = r_i + 8'd1;
               w_s_address = r_i + 8'd1;
            end
         end
         default: begin
            w_finish = 1'b0;
         end
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_i           <= 8'd0;
         r_j           <= 8'd0;
         r_k           <= 8'd0;
         r_si          <= 8'd0;
         r_sj          <= 8'd0;
         r_finish      <= 1'b0;
         r_valid       <= 1'b0;
         r_s_address   <= 8'd0;
         r_s_data      <= 8'd0;
         r_s_wren      <= 1'b0;
         r_rom_address <= '0;
         r_ram_address <= '0;
         r_ram_data    <= 8'd0;
         r_ram_wren    <= 1'b0;
      end else begin
         r_i           <= w_i;
         r_j           <= w_j;
         r_k           <= w_k;
         r_si          <= w_si;
         r_sj          <= w_sj;
         r_finish      <= w_finish;
         r_valid       <= w_valid;
         r_s_address   <= w_s_address;
         r_s_data      <= w_s_data;
         r_s_wren      <= w_s_wren;
         r_rom_address <= w_rom_address;
         r_ram_address <= w_ram_address;
         r_ram_data    <= w_ram_data;
         r_ram_wren    <= w_ram_wren;
      end
   end

   assign finish      = r_finish;
   assign valid       = r_valid;
   assign s_address   = r_s_address;
   assign s_data      = r_s_data;
   assign s_wren      = r_s_wren;
   assign rom_address = r_rom_address;
   assign ram_address = r_ram_address;
   assign ram_data    = r_ram_data;
   assign ram_wren    = r_ram_wren;

endmodule

// File: tb/tb_prga_decrypt.sv
// Scoreboard bench for prga_decrypt with MSG_LEN=4: expected plaintext writes
// and finish events are queued by the stimulus and checked by a negedge monitor.
module tb_prga_decrypt;

   localparam int MSG_LEN = 4;
   localparam int AW      = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          finish, valid;
   logic [7:0]    s_address, s_data, s_q;
   logic          s_wren;
   logic [AW-1:0] rom_address, ram_address;
   logic [7:0]    rom_q, ram_data;
   logic          ram_wren;

   prga_decrypt #(.MSG_LEN(MSG_LEN)) dut (
      .clk(clk), .reset(reset), .start(start), .finish(finish), .valid(valid),
      .s_address(s_address), .s_data(s_data), .s_wren(s_wren), .s_q(s_q),
      .rom_address(rom_address), .rom_q(rom_q),
      .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren)
   );

   always #5 clk = ~clk;

   logic [7:0] s_mem  [256];
   logic [7:0] s_init [256];
   logic       s_reload = 1'b0;
   logic [7:0] rom_mem [MSG_LEN];
   logic [7:0] pt_mem  [MSG_LEN];
   int         edge_cnt = 0;

   // Synchronous memories with one-cycle read latency
   always @(posedge clk) begin
      edge_cnt <= edge_cnt + 1;
      if (s_reload) begin
         for (int x = 0; x < 256; x++) s_mem[x] <= s_init[x];
      end else if (s_wren) begin
         s_mem[s_address] <= s_data;
      end
      s_q   <= s_mem[s_address];
      rom_q <= rom_mem[rom_address];
      if (ram_wren) pt_mem[ram_address] <= ram_data;
   end

   typedef struct {
      bit         is_fin;
      logic [7:0] addr;
      logic [7:0] data;
      int         cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   fin_cnt = 0;
   int   run_t0  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic flag(input string name, input logic [31:0] act);
      n_tests++;
      n_fail++;
      $display("FAIL %s: got %0h, no event expected", name, act);
   endtask

   // Monitor: pops the scoreboard on every plaintext write and finish pulse
   always @(negedge clk) begin
      if (reset === 1'b1) begin
         if (ram_wren) begin
            if (sb.size() == 0 || sb[0].is_fin) begin
               flag("unexpected_ram_write", {22'd0, ram_address, ram_data});
            end else begin
               mon_e = sb.pop_front();
               check("ram_addr", 32'(ram_address), 32'(mon_e.addr));
               check("ram_data", 32'(ram_data), 32'(mon_e.data));
            end
         end
         if (finish) begin
            fin_cnt++;
            if (sb.size() == 0 || !sb[0].is_fin) begin
               flag("unexpected_finish", 32'(edge_cnt - run_t0 + 1));
            end else begin
               mon_e = sb.pop_front();
               check("finish_cycle", 32'(edge_cnt - run_t0 + 1), 32'(mon_e.cyc));
               check("finish_valid", 32'(valid), 32'(mon_e.data[0]));
            end
         end
      end
   end

   task automatic push_w(input logic [7:0] a, input logic [7:0] d);
      exp_t e;
      e.is_fin = 1'b0; e.addr = a; e.data = d; e.cyc = 0;
      sb.push_back(e);
   endtask

   task automatic push_f(input int cyc, input logic v);
      exp_t e;
      e.is_fin = 1'b1; e.addr = 8'd0; e.data = {7'd0, v}; e.cyc = cyc;
      sb.push_back(e);
   endtask

   task automatic fill_identity();
      for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
   endtask

   task automatic load_s();
      @(negedge clk);
      s_reload = 1'b1;
      @(negedge clk);
      s_reload = 1'b0;
   endtask

   task automatic set_rom(input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3);
      rom_mem[0] = b0; rom_mem[1] = b1; rom_mem[2] = b2; rom_mem[3] = b3;
   endtask

   task automatic push_basic();
      push_w(8'd0, 8'h61); push_w(8'd1, 8'h62); push_w(8'd2, 8'h63); push_w(8'd3, 8'h20);
      push_f(37, 1'b1);
   endtask

   task automatic begin_run();
      @(negedge clk);
      start  = 1'b1;
      run_t0 = edge_cnt + 1;
      @(negedge clk);
      start  = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_finish(input int budget);
      int c0 = fin_cnt;
      int n  = 0;
      while (fin_cnt == c0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (fin_cnt == c0) flag("finish_timeout", 32'(n));
      repeat (2) @(negedge clk);
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_finish"},  32'(finish), 32'd0);
      check({tag, "_valid"},   32'(valid), 32'd0);
      check({tag, "_s_wren"},  32'(s_wren), 32'd0);
      check({tag, "_ram_wren"},32'(ram_wren), 32'd0);
      check({tag, "_s_addr"},  32'(s_address), 32'd0);
      check({tag, "_rom_addr"},32'(rom_address), 32'd0);
      check({tag, "_ram_addr"},32'(ram_address), 32'd0);
   endtask

   task automatic check_basic_s();
      check("s2", 32'(s_mem[2]), 32'h3);
      check("s3", 32'(s_mem[3]), 32'h5);
      check("s4", 32'(s_mem[4]), 32'h9);
      check("s5", 32'(s_mem[5]), 32'h2);
      check("s9", 32'(s_mem[9]), 32'h4);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      reset = 1'b0;
      start = 1'b0;
      repeat (3) @(negedge clk);
      check_zero_outputs("rst");
      reset = 1'b1;

      // Identity S, normal four-byte decrypt
      fill_identity(); load_s();
      set_rom(8'h63, 8'h67, 8'h64, 8'h2D);
      push_basic();
      begin_run();
      wait_finish(60);
      check("basic_valid_held", 32'(valid), 32'd1);
      check("basic_pt3", 32'(pt_mem[3]), 32'h20);
      check_basic_s();

      // All-zero ciphertext aborts on the first byte
      fill_identity(); load_s();
      set_rom(8'h00, 8'h00, 8'h00, 8'h00);
      push_w(8'd0, 8'h02);
      push_f(10, 1'b0);
      begin_run();
      wait_finish(60);
      repeat (20) @(negedge clk);
      check("abort_valid", 32'(valid), 32'd0);
      check("abort_sb_empty", 32'(sb.size()), 32'd0);

      // Start pulsed in WAIT_J of byte 0 is ignored
      fill_identity(); load_s();
      set_rom(8'h63, 8'h67, 8'h64, 8'h2D);
      push_basic();
      begin_run();
      repeat (2) @(negedge clk);
      pulse_start();
      wait_finish(60);
      check_basic_s();

      // Reset in cycle 15 abandons the run without finish
      fill_identity(); load_s();
      push_w(8'd0, 8'h61);
      begin_run();
      repeat (14) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_zero_outputs("midrst");
      reset = 1'b1;
      c0 = fin_cnt;
      repeat (50) @(negedge clk);
      check("midrst_no_finish", 32'(fin_cnt), 32'(c0));
      check("midrst_sb_empty", 32'(sb.size()), 32'd0);
      fill_identity(); load_s();
      push_basic();
      begin_run();
      wait_finish(60);
      check_basic_s();

      // Index wrap: S[1]=FF, S[FF]=01
      fill_identity();
      s_init[1] = 8'hFF; s_init[255] = 8'h01;
      load_s();
      set_rom(8'h77, 8'h71, 8'h66, 8'h7A);
      push_w(8'd0, 8'h77); push_w(8'd1, 8'h72); push_w(8'd2, 8'h61); push_w(8'd3, 8'h70);
      push_f(37, 1'b1);
      begin_run();
      repeat (2) @(negedge clk);
      check("wrap_j_addr", 32'(s_address), 32'hFF);
      repeat (4) @(negedge clk);
      check("wrap_f_addr", 32'(s_address), 32'h00);
      wait_finish(60);
      check("wrap_s1",  32'(s_mem[1]), 32'h2);
      check("wrap_s2",  32'(s_mem[2]), 32'h1);
      check("wrap_s4",  32'(s_mem[4]), 32'h7);
      check("wrap_s7",  32'(s_mem[7]), 32'h3);
      check("wrap_sff", 32'(s_mem[255]), 32'hFF);

      // Back-to-back: start held through DONE (ignored) and IDLE (accepted)
      fill_identity(); load_s();
      set_rom(8'h63, 8'h67, 8'h64, 8'h2D);
      push_basic();
      begin_run();
      repeat (36) @(negedge clk);
      start    = 1'b1;
      s_reload = 1'b1;
      push_basic();
      @(negedge clk);
      s_reload = 1'b0;
      check("b2b_valid_held", 32'(valid), 32'd1);
      run_t0 = edge_cnt + 1;
      @(negedge clk);
      start = 1'b0;
      check("b2b_valid_cleared", 32'(valid), 32'd0);
      wait_finish(60);
      check_basic_s();

      repeat (5) @(negedge clk);
      check("final_sb_empty", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/prga_decrypt.md
PRGA_DECRYPT -- requirements
Module: prga_decrypt

Interface
REQ-001 SHALL have parameter: MSG_LEN, 32, number of ciphertext bytes processed (1..256).
REQ-002 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port: start  input  1  one-cycle request to begin; ignored unless in IDLE.
REQ-005 SHALL have port: finish  output  1  one-cycle pulse on completion or abort.
REQ-006 SHALL have port: valid  output  1  level, held until next start: 1 = all MSG_LEN bytes decrypted to legal characters.
REQ-007 SHALL have ports: s_address  output  8; s_data  output  8; s_wren  output  1; s_q  input  8. These form the S-array RAM port.
REQ-008 SHALL have ports: rom_address  output  $clog2(MSG_LEN); rom_q  input  8. These form the ciphertext ROM port.
REQ-009 SHALL have ports: ram_address  output  $clog2(MSG_LEN); ram_data  output  8; ram_wren  output  1. These form the plaintext RAM port.

Function
REQ-010 SHALL treat all RAM/ROM reads as 1-cycle latency: q is sampled one cycle after the address is driven.
REQ-011 SHALL implement the RC4 PRGA with 8-bit registers i, j and k; i, j and S-index sums SHALL wrap mod 256.
- i and j start at 0.
- Per byte k: i=i+1; si=S[i]; j=j+si; sj=S[j]; S[i]=sj; S[j]=si; f=S[si+sj]; out[k]=f XOR enc[k].
REQ-012 SHALL use FSM states IDLE, READ_I, WAIT_I, READ_J, WAIT_J, WRITE_I, WRITE_J, READ_F, WAIT_F, WRITE_OUT, DONE. Each state lasts one cycle, giving 9 cycles per byte.
REQ-013 SHALL transition IDLE->READ_I on start, which clears k, i, j and valid.
REQ-014 SHALL drive addresses per state:
- READ_I: s_address = i+1.
- READ_J: s_address = j+s_q.
- READ_F: s_address = si+sj and rom_address = k.
REQ-015 SHALL assert s_wren only in WRITE_I (data sj at i) and WRITE_J (data si at j), and ram_wren only in WRITE_OUT (address k, data f XOR rom_q).
REQ-016 SHALL handle the i == j case by performing both writes; the final S[i] equals the original value.
REQ-017 SHALL treat only bytes 0x61..0x7A and 0x20 as legal. An illegal byte is still written, then the FSM goes to DONE with valid=0 (abort).
REQ-018 SHALL, in WRITE_OUT with k == MSG_LEN-1 and a legal byte, go to DONE with valid=1. Otherwise k increments and the FSM returns to READ_I.
REQ-019 SHALL hold finish=1 for exactly one cycle in DONE, then return to IDLE.
REQ-020 SHALL, after a start sampled at edge 0, pulse finish in cycle 9*N+1, where N is the number of bytes processed (N = MSG_LEN unless aborted).
REQ-021 SHALL ignore start in any state other than IDLE, including DONE.
REQ-022 SHALL deassert s_wren and ram_wren in every state except those named in REQ-015.

Reset
REQ-023 SHALL, when reset=0 at a clock edge, enter IDLE and clear i, j, k, si, sj, finish, valid, s_wren, ram_wren and all addresses to 0.
REQ-024 SHALL abandon any in-progress operation on reset mid-operation without emitting finish. S and plaintext memory contents are not restored.

Structure
REQ-025 SHALL take the FSM state enum, MSG_LEN default and legal-character bounds from shared package rc4_pkg. Upstream swap/initialize stages also use this package.
REQ-026 SHALL be a single module with no sub-module. The legal-character check SHALL be a function in rc4_pkg.

Verification
REQ-027 SHALL cover: S identity (S[x]=x), MSG_LEN=4, enc = 63 67 64 2D.
- Expected plaintext 61 62 63 20, valid=1, finish at cycle 37.
- Expected final S[2]=3, S[3]=5, S[4]=9, S[5]=2, S[9]=4.
REQ-028 SHALL cover: S identity, enc all 00.
- First output is 02 (illegal), written at ram address 0.
- Expected finish at cycle 10, valid=0, no ram write at address 1.
REQ-029 SHALL cover: start pulsed in WAIT_J of byte 0. Expected: ignored; timing and results identical to REQ-027.
REQ-030 SHALL cover: reset=0 in cycle 15 of the REQ-027 run. Expected: IDLE next cycle, all outputs 0, no finish; a new start then runs normally.
REQ-031 SHALL cover: S with S[1]=0xFF, S[0xFF]=1, rest identity. Expected: j wraps to 0xFF, f read from address 0x00 (0xFF+0x01 wraps to 0x00).
REQ-032 SHALL cover: two back-to-back starts, the second one cycle after finish. Expected: second run accepted, valid cleared at its start.
